// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: DEPTH-entry scoreboard (EX..WB), operand forwarding select,
// load-use / scoreboard stall, branch flush and saturating stall counter.
// Optional feature macro: HAZARD_FWD_EN (forwarding enabled when defined).
module hazard_ctrl #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_id,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic             rs1use,
   input  logic             rs2use,
   input  logic [4:0]       rd_id,
   input  logic [1:0]       hazard_optype,
   input  logic             branch_id,
   output logic             stall_if,
   output logic             stall_id,
   output logic             bubble_ex,
   output logic             flush_if,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned RW = 5;

   typedef struct packed {
      logic          v;
      logic [RW-1:0] rd;
      logic          ld;
   } entry_t;

   entry_t           sb [DEPTH];
   logic [CNT_W-1:0] cnt_q;
   logic [DEPTH-2:0] m_a;
   logic [DEPTH-2:0] m_b;
   logic             load_use;
   logic             sb_hit;
   logic             stall;
   logic             push;
   logic [1:0]       sel_a;
   logic [1:0]       sel_b;

   // Source matches against every entry that can still be a hazard (WB excluded).
   always_comb begin : match
      m_a = '0;
      m_b = '0;
      for (int unsigned k = 0; k < DEPTH - 1; k++) begin
         m_a[k] = rs1use && (rs1_id != '0) && sb[k].v && (sb[k].rd == rs1_id);
         m_b[k] = rs2use && (rs2_id != '0) && sb[k].v && (sb[k].rd == rs2_id);
      end
   end

`ifdef HAZARD_FWD_EN
   // Youngest match wins; a load still in EX cannot forward, it stalls instead.
   function automatic logic [1:0] fwd_pick(input logic [1:0] m, input logic ld0,
                                           input logic ld1);
      logic [1:0] sel;
      sel = 2'b00;
      if (m[0])      sel = ld0 ? 2'b00 : 2'b01;
      else if (m[1]) sel = ld1 ? 2'b11 : 2'b10;
      return sel;
   endfunction

   always_comb begin : hazard_fwd
      load_use = sb[0].ld && (m_a[0] || m_b[0]);
      sb_hit   = 1'b0;
      for (int unsigned k = 2; k < DEPTH - 1; k++) begin
         sb_hit = sb_hit | m_a[k] | m_b[k];
      end
      sel_a = fwd_pick(m_a[1:0], sb[0].ld, sb[1].ld);
      sel_b = fwd_pick(m_b[1:0], sb[0].ld, sb[1].ld);
   end
`else
   always_comb begin : hazard_nofwd
      load_use = 1'b0;
      sb_hit   = (|m_a) || (|m_b);
      sel_a    = 2'b00;
      sel_b    = 2'b00;
   end
`endif

   assign stall = rst_n && valid_id && (load_use || sb_hit);
   assign push  = valid_id && (hazard_optype == 2'b01 || hazard_optype == 2'b10)
                  && (rd_id != '0) && !stall;

   assign stall_if  = stall;
   assign stall_id  = stall;
   assign bubble_ex = stall;
   assign flush_if  = rst_n && branch_id && !stall;
   assign fwd_a     = rst_n ? sel_a : 2'b00;
   assign fwd_b     = rst_n ? sel_b : 2'b00;
   assign stall_cnt = cnt_q;

   // Scoreboard shifts every cycle; a stalled ID injects an empty slot into EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) sb[k] <= '0;
         cnt_q <= '0;
      end else begin
         for (int unsigned k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
         sb[0] <= '{v: push, rd: rd_id, ld: (hazard_optype == 2'b10)};
         if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule
